// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: opcode encodings
// seen on md_op and the control FSM state type.
package muldiv_ctrl_pkg;

  // Opcodes driven by the EX stage alongside the ALU controls.
  localparam logic [2:0] MD_NOP   = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  // Sequencer states: wait for an op, iterate one bit per cycle, sign-fix.
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared multiply/divide datapath.
//  Multiply (shift-add): if q[0], add b into acc; then shift {carry,acc,q}
//    right by one. After WIDTH steps {acc,q} holds the full product.
//  Divide (restoring): shift {acc,q} left by one, trial-subtract b from the
//    widened remainder, keep the difference when it does not borrow and
//    shift the resulting quotient bit into q.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH:0] w_sum;      // multiply: acc + (q[0] ? b : 0), with carry
  logic [WIDTH:0] w_shifted;  // divide: remainder shifted left by one bit
  logic           w_ge;       // divide: trial subtraction does not borrow

  assign w_sum     = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_b} : '0);
  assign w_shifted = {i_acc, i_q[WIDTH-1]};
  assign w_ge      = (w_shifted >= {1'b0, i_b});

  // Select the multiply or divide update of {acc,q}.
  // NOTE: every output gets a default first so no path through this block can infer a latch.
  always_comb begin
    o_acc = i_acc;
    o_q   = i_q;
    if (i_is_div) begin
      // The remainder is always < b after a step, so it fits in WIDTH bits.
      o_acc = w_ge ? WIDTH'(w_shifted - {1'b0, i_b}) : w_shifted[WIDTH-1:0];
      o_q   = {i_q[WIDTH-2:0], w_ge};
    end else begin
      o_acc = w_sum[WIDTH:1];
      o_q   = {w_sum[0], i_q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer with architectural HI/LO registers.
// Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, iterates one bit per cycle
// and holds md_busy so hazard logic stalls later muldiv ops and MFHI/MFLO.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             md_start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] md_src_a,
  input  logic [WIDTH-1:0] md_src_b,
  input  logic             md_flush,
  output logic             md_busy,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc, r_q, r_opnd;
  logic             r_is_div, r_sign_q, r_sign_r, r_div0;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic             r_done;

  logic             w_accept, w_start_md, w_leave_fix;
  logic             w_is_arith, w_is_div_op, w_signed_op;
  logic             w_neg_a, w_neg_b;
  logic [WIDTH-1:0] w_abs_a, w_abs_b;
  logic [WIDTH-1:0] w_step_acc, w_step_q;
  logic [2*WIDTH-1:0] w_prod, w_prod_neg;
  logic [WIDTH-1:0] w_res_hi, w_res_lo;

  // Flush wins over start, and starts are only taken while idle.
  assign w_accept    = md_start && (r_state == MD_IDLE) && !md_flush;
  assign w_is_arith  = (md_op == MD_MULT) || (md_op == MD_MULTU) ||
                       (md_op == MD_DIV)  || (md_op == MD_DIVU);
  assign w_is_div_op = (md_op == MD_DIV) || (md_op == MD_DIVU);
  assign w_signed_op = (md_op == MD_MULT) || (md_op == MD_DIV);
  assign w_start_md  = w_accept && w_is_arith;
  assign w_leave_fix = (r_state == MD_FIX) && !md_flush;

  // Iterate on magnitudes; signs are reapplied in FIX.
  assign w_neg_a = w_signed_op && md_src_a[WIDTH-1];
  assign w_neg_b = w_signed_op && md_src_b[WIDTH-1];
  assign w_abs_a = w_neg_a ? -md_src_a : md_src_a;
  assign w_abs_b = w_neg_b ? -md_src_b : md_src_b;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_is_div (r_is_div),
    .i_acc    (r_acc),
    .i_q      (r_q),
    .i_b      (r_opnd),
    .o_acc    (w_step_acc),
    .o_q      (w_step_q)
  );

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= MD_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: IDLE -> CALC (WIDTH cycles) -> FIX (1 cycle) -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MD_IDLE: if (w_start_md) w_state_nxt = MD_CALC;
      MD_CALC: begin
        if (md_flush)         w_state_nxt = MD_IDLE;
        else if (r_cnt == '0) w_state_nxt = MD_FIX;
      end
      MD_FIX:  w_state_nxt = MD_IDLE;
      default: w_state_nxt = MD_IDLE;
    endcase
  end

  // Iteration datapath: latch operands on accept, step once per CALC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_div0   <= 1'b0;
    end else if (w_start_md) begin
      // Divide iterates on q=dividend, b=divisor; multiply on q=multiplier.
      r_cnt    <= CNT_W'(WIDTH - 1);
      r_acc    <= '0;
      r_q      <= w_is_div_op ? w_abs_a : w_abs_b;
      r_opnd   <= w_is_div_op ? w_abs_b : w_abs_a;
      r_is_div <= w_is_div_op;
      r_sign_q <= w_neg_a ^ w_neg_b;
      r_sign_r <= w_neg_a;
      r_div0   <= w_is_div_op && (md_src_b == '0);
    end else if (r_state == MD_CALC) begin
      r_acc <= w_step_acc;
      r_q   <= w_step_q;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign w_prod     = {r_acc, r_q};
  assign w_prod_neg = -w_prod;

  // Sign correction of the finished iteration. Dividing by zero leaves
  // |a| in the remainder, so the dividend-sign fix restores src_a exactly.
  always_comb begin
    w_res_hi = r_acc;
    w_res_lo = r_q;
    if (r_is_div) begin
      w_res_lo = r_div0 ? '1 : (r_sign_q ? -r_q : r_q);
      w_res_hi = r_sign_r ? -r_acc : r_acc;
    end else begin
      {w_res_hi, w_res_lo} = r_sign_q ? w_prod_neg : w_prod;
    end
  end

  // HI/LO: MT writes on accept, MUL/DIV results on the edge leaving FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_accept && (md_op == MD_MTHI)) begin
      r_hi <= md_src_a;
    end else if (w_accept && (md_op == MD_MTLO)) begin
      r_lo <= md_src_a;
    end else if (w_leave_fix) begin
      r_hi <= w_res_hi;
      r_lo <= w_res_lo;
    end
  end

  // One-cycle completion pulse, coincident with the new HI/LO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_done <= 1'b0;
    else        r_done <= w_leave_fix;
  end

  assign md_busy = (r_state != MD_IDLE);
  assign md_done = r_done;
  assign hi      = r_hi;
  assign lo      = r_lo;

endmodule
